key_expand_ctrl: RTL and testbench
==================================

// Module: key_expand_ctrl
// PURPOSE
//  Sequences the g_module datapath to expand an AES-128 cipher key into round keys 0..NUM_ROUNDS.
//  Holds the current 128-bit round key in a register and drives g_module with g_in = w3 and g_round = next round number.
//  Forms w4..w7 by XOR chain and streams each round key out over a valid/ready handshake.
//  Sits between key load logic and the round-key consumer (cipher core or key RAM writer).
// PARAMETERS
//  NUM_ROUNDS   10  last round index emitted; only 10 (AES-128) is legal, since g_round and rcon cover 1..10
//  EMIT_ROUND0  1   1: emit cipher key itself as round 0; 0: first emitted key is round 1
// PORTS
//  clk        in   1    single clock, all state on rising edge
//  rst        in   1    synchronous, active-high reset
//  start      in   1    request expansion of key_in; accepted only when busy=0
//  key_in     in   128  cipher key; [127:96]=w0 ... [31:0]=w3; sampled on accepted start only
//  busy       out  1    1 from cycle after accepted start until done pulse cycle inclusive
//  rk_valid   out  1    rk_data/rk_index hold a valid round key
//  rk_ready   in   1    consumer accepts key when rk_valid & rk_ready at clk edge
//  rk_data    out  128  round key, same word order as key_in
//  rk_index   out  4    round number of rk_data (0..10)
//  done       out  1    one-cycle pulse after round NUM_ROUNDS is accepted
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, rk_valid=0, rk_data=0, rk_index=0, done=0; internal key reg=0.
//  Reset is honoured in any state: an expansion in flight is abandoned and no done pulse is issued.
//  FSM states: IDLE, EMIT, DONE.
//  IDLE:
//   - start=1 -> key reg<=key_in, go to EMIT.
//   - If EMIT_ROUND0=1: rk_index<=0, rk_data<=key_in.
//   - Else: the round-1 key is computed from key_in the same cycle and loaded, rk_index<=1.
//   - rk_valid<=1, busy<=1. Latency: start at cycle T -> rk_valid=1 at T+1.
//  EMIT:
//   - rk_valid=1 is held.
//   - rk_valid & !rk_ready: rk_data/rk_index held stable, no state change.
//   - Handshake with rk_index<NUM_ROUNDS: next key registered at that edge, rk_index+1.
//     rk_valid stays high, so with rk_ready tied 1 one key issues per cycle.
//   - Handshake with rk_index==NUM_ROUNDS: rk_valid<=0, done<=1, go to DONE.
//  DONE:
//   - done=1 and busy=1 for exactly one cycle, then done<=0, busy<=0, go to IDLE.
//   - rk_data/rk_index retain their last values.
//  Next-key arithmetic (r = rk_index+1, 4-bit):
//   - g_in = w3, g_round = r.
//   - w4 = w0^g_out; w5 = w4^w1; w6 = w5^w2; w7 = w6^w3; next key = {w4,w5,w6,w7}.
//   - g_module is combinational: no extra pipeline cycle; round counter never exceeds NUM_ROUNDS, no wrap.
//  start while busy=1 (including the DONE cycle): ignored, key_in not sampled.
//  A start in the first IDLE cycle after DONE is accepted normally (back-to-back expansions allowed).
//  rk_ready while rk_valid=0: ignored.
//  No combinational path from rk_ready or start to any output.
// TESTING
//  1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, start at T -> rk_index 0..10 at T+1..T+11.
//     Round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done at T+12 only.
//  2. Same key, rk_ready low 3 cycles while rk_index=4 -> rk_data/rk_index stable; next edge with ready gives round 5 = d4d1c6f87c839d87caf2b8bc11f915bc.
//  3. All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
//  4. start pulsed at rk_index=6 with different key_in -> ignored; sequence completes with original key.
//  5. rst asserted at rk_index=7 -> next cycle busy=0, rk_valid=0, rk_data=0, no done; new start then runs a full 0..10 sequence.
//  6. EMIT_ROUND0=0, test-1 key -> first rk_valid at T+1 with rk_index=1 = a0fafe17...; 10 keys total; done after round 10.

Source files
------------

// File: rtl/key_expand_ctrl.sv
// AES-128 key expansion sequencer: holds the current round key, derives the next one through
// g_module, and streams round keys 0..NUM_ROUNDS (or 1..NUM_ROUNDS) over a valid/ready port.

module g_module (
  input  logic [31:0] g_in,
  input  logic [3:0]  g_round,
  output logic [31:0] g_out
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  logic [31:0] rot;
  logic [7:0]  rcon;

  always_comb begin
    rot = {g_in[23:0], g_in[31:24]};
    unique case (g_round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    g_out = {sub_byte(rot[31:24]) ^ rcon, sub_byte(rot[23:16]),
             sub_byte(rot[15:8]), sub_byte(rot[7:0])};
  end
endmodule

module key_expand_ctrl #(
  parameter int unsigned NUM_ROUNDS  = 10,
  parameter bit          EMIT_ROUND0 = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done
);
  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} state_t;

  state_t       state;
  logic [127:0] src_key;
  logic [127:0] next_key;
  logic [3:0]   g_round;
  logic [31:0]  g_out;
  logic [31:0]  w4, w5, w6, w7;

  // rk_data doubles as the current-round key register; in IDLE the g path
  // works on key_in so a skipped round 0 still costs no extra cycle.
  always_comb begin
    src_key  = (state == IDLE) ? key_in : rk_data;
    g_round  = (state == IDLE) ? 4'd1 : rk_index + 4'd1;
    w4       = src_key[127:96] ^ g_out;
    w5       = w4 ^ src_key[95:64];
    w6       = w5 ^ src_key[63:32];
    w7       = w6 ^ src_key[31:0];
    next_key = {w4, w5, w6, w7};
  end

  g_module u_g (
    .g_in    (src_key[31:0]),
    .g_round (g_round),
    .g_out   (g_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            state    <= EMIT;
            if (EMIT_ROUND0) begin
              rk_data  <= key_in;
              rk_index <= 4'd0;
            end else begin
              rk_data  <= next_key;
              rk_index <= 4'd1;
            end
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (rk_index == 4'(NUM_ROUNDS)) begin
              rk_valid <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              rk_data  <= next_key;
              rk_index <= rk_index + 4'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expand_ctrl.sv
// Randomized self-checking bench for key_expand_ctrl against a FIPS-197 key-schedule model
// whose S-box is derived from GF(2^8) inversion plus the affine map.

module tb_key_expand_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start_a, rk_ready_a, busy_a, rk_valid_a, done_a;
  logic [127:0] key_in_a, rk_data_a;
  logic [3:0]   rk_index_a;
  logic         start_b, rk_ready_b, busy_b, rk_valid_b, done_b;
  logic [127:0] key_in_b, rk_data_b;
  logic [3:0]   rk_index_b;

  key_expand_ctrl #(.NUM_ROUNDS(10), .EMIT_ROUND0(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .key_in(key_in_a), .busy(busy_a),
    .rk_valid(rk_valid_a), .rk_ready(rk_ready_a), .rk_data(rk_data_a),
    .rk_index(rk_index_a), .done(done_a)
  );

  key_expand_ctrl #(.NUM_ROUNDS(10), .EMIT_ROUND0(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .key_in(key_in_b), .busy(busy_b),
    .rk_valid(rk_valid_b), .rk_ready(rk_ready_b), .rk_data(rk_data_b),
    .rk_index(rk_index_b), .done(done_b)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [7:0]   sbox_t[256];
  logic [127:0] exp_rk[11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [15:0] d = {v, v};
    return d[15-k -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]] ^ rc, sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // ---------------- stream capture (no checking) ----------------
  logic [127:0] cap_data[$];
  int           cap_idx[$];
  int           first_valid, done_cyc, done_cnt, stall_bad, stall_cycles;
  logic         busy_at_done, busy_after;
  bit           timed_out;

  // Called at a negedge with dut_a idle; starts an expansion and records every handshake.
  task automatic capture(input logic [127:0] key, input int mode, input int inject_at,
                         input logic [127:0] other_key, input bit start_in_done);
    int           stall_run = 0;
    bit           injected = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;
    logic [3:0]   prev_idx = '0;
    cap_data.delete(); cap_idx.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; stall_bad = 0; stall_cycles = 0;
    busy_at_done = 1'bx; busy_after = 1'bx; timed_out = 0;
    key_in_a = key; start_a = 1'b1; rk_ready_a = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (prev_stall && (rk_data_a !== prev_data || rk_index_a !== prev_idx)) stall_bad++;
      if (rk_valid_a === 1'b1 && first_valid < 0) first_valid = c;
      if (done_a === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          busy_at_done = busy_a;
          if (start_in_done) begin start_a = 1'b1; key_in_a = other_key; end
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        busy_after = busy_a;
        rk_ready_a = 1'b1;
        return;
      end
      case (mode)
        1: rk_ready_a = 1'($urandom_range(0, 1));
        2: if (rk_valid_a && rk_index_a == 4'd4 && stall_run < 3) begin
             rk_ready_a = 1'b0; stall_run++;
           end else rk_ready_a = 1'b1;
        default: rk_ready_a = 1'b1;
      endcase
      if (rk_valid_a && rk_ready_a) begin
        cap_data.push_back(rk_data_a);
        cap_idx.push_back(int'(rk_index_a));
      end
      if (rk_valid_a && !rk_ready_a) stall_cycles++;
      prev_stall = rk_valid_a && !rk_ready_a;
      prev_data = rk_data_a; prev_idx = rk_index_a;
      if (inject_at >= 0 && !injected && rk_valid_a && int'(rk_index_a) == inject_at) begin
        start_a = 1'b1; key_in_a = other_key; injected = 1;
      end
    end
    timed_out = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start_a = 0; start_b = 0; rk_ready_a = 1; rk_ready_b = 1;
    key_in_a = '1; key_in_b = '1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, rk_valid_a, done_a, rk_index_a} !== 7'd0 || rk_data_a !== '0) begin
      errors++; $display("FAIL reset_a: busy=%b valid=%b done=%b idx=%0d data=%h, want all 0",
                         busy_a, rk_valid_a, done_a, rk_index_a, rk_data_a);
    end
    checks++;
    if ({busy_b, rk_valid_b, done_b, rk_index_b} !== 7'd0 || rk_data_b !== '0) begin
      errors++; $display("FAIL reset_b: busy=%b valid=%b done=%b idx=%0d data=%h, want all 0",
                         busy_b, rk_valid_b, done_b, rk_index_b, rk_data_b);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || rk_valid_a !== 1'b0) begin
      errors++; $display("FAIL idle_no_start: busy=%b valid=%b, want 0 0", busy_a, rk_valid_a);
    end
  endtask

  task automatic test_fips_vectors();
    model_expand(K1);
    capture(K1, 0, -1, '0, 0);
    checks++;
    if (timed_out || cap_data.size() != 11) begin
      errors++; $display("FAIL fips_count: timeout=%0d keys=%0d, want 0 11", timed_out, cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 11; i++) begin
      checks++;
      if (cap_idx[i] !== i || cap_data[i] !== exp_rk[i]) begin
        errors++; $display("FAIL fips_round%0d: idx=%0d data=%h, want idx=%0d data=%h",
                           i, cap_idx[i], cap_data[i], i, exp_rk[i]);
      end
    end
    if (cap_data.size() == 11) begin
      checks++;
      if (cap_data[1] !== R1 || cap_data[10] !== R10) begin
        errors++; $display("FAIL fips_const: r1=%h r10=%h, want %h %h", cap_data[1], cap_data[10], R1, R10);
      end
    end
    checks++;
    if (first_valid != 1 || done_cyc != 12 || done_cnt != 1) begin
      errors++; $display("FAIL fips_timing: first=%0d done_at=%0d pulses=%0d, want 1 12 1",
                         first_valid, done_cyc, done_cnt);
    end
    checks++;
    if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
      errors++; $display("FAIL fips_busy: at_done=%b after=%b, want 1 0", busy_at_done, busy_after);
    end
    checks++;
    if (rk_data_a !== R10 || rk_index_a !== 4'd10) begin
      errors++; $display("FAIL fips_retain: idx=%0d data=%h, want 10 %h", rk_index_a, rk_data_a, R10);
    end
  endtask

  task automatic test_backpressure();
    model_expand(K1);
    capture(K1, 2, -1, '0, 0);
    checks++;
    if (stall_bad != 0 || stall_cycles != 3) begin
      errors++; $display("FAIL stall_hold: changed=%0d stalls=%0d, want 0 3", stall_bad, stall_cycles);
    end
    checks++;
    if (cap_data.size() != 11 || cap_data[5] !== R5 || done_cyc != 15) begin
      errors++; $display("FAIL stall_round5: keys=%0d r5=%h done_at=%0d, want 11 %h 15",
                         cap_data.size(), (cap_data.size() > 5) ? cap_data[5] : '0, done_cyc, R5);
    end
    for (int n = 0; n < 4; n++) begin
      logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
      int bad = 0;
      model_expand(key);
      capture(key, 1, -1, '0, 0);
      for (int i = 0; i < cap_data.size(); i++)
        if (i > 10 || cap_idx[i] !== i || cap_data[i] !== exp_rk[i]) bad++;
      checks++;
      if (timed_out || bad != 0 || cap_data.size() != 11 || stall_bad != 0 ||
          done_cyc != 12 + stall_cycles || done_cnt != 1) begin
        errors++; $display("FAIL random_ready%0d: bad=%0d keys=%0d held_err=%0d done_at=%0d pulses=%0d, want 0 11 0 %0d 1",
                           n, bad, cap_data.size(), stall_bad, done_cyc, done_cnt, 12 + stall_cycles);
      end
    end
  endtask

  task automatic test_zero_key();
    int bad = 0;
    model_expand('0);
    capture('0, 0, -1, '0, 0);
    for (int i = 0; i < cap_data.size(); i++)
      if (i > 10 || cap_idx[i] !== i || cap_data[i] !== exp_rk[i]) bad++;
    checks++;
    if (bad != 0 || cap_data.size() != 11) begin
      errors++; $display("FAIL zero_seq: bad=%0d keys=%0d, want 0 11", bad, cap_data.size());
    end
    checks++;
    if (cap_data.size() != 11 || cap_data[1] !== Z1 || cap_data[10] !== Z10) begin
      errors++; $display("FAIL zero_const: keys=%0d, want 11 with r1=%h r10=%h", cap_data.size(), Z1, Z10);
    end
  endtask

  task automatic test_start_ignored();
    int bad = 0;
    model_expand(K1);
    capture(K1, 0, 6, {$urandom, $urandom, $urandom, $urandom}, 1);
    for (int i = 0; i < cap_data.size(); i++)
      if (i > 10 || cap_idx[i] !== i || cap_data[i] !== exp_rk[i]) bad++;
    checks++;
    if (bad != 0 || cap_data.size() != 11 || done_cyc != 12 || done_cnt != 1) begin
      errors++; $display("FAIL busy_start: bad=%0d keys=%0d done_at=%0d pulses=%0d, want 0 11 12 1",
                         bad, cap_data.size(), done_cyc, done_cnt);
    end
    checks++;
    if (busy_after !== 1'b0 || rk_valid_a !== 1'b0) begin
      errors++; $display("FAIL done_cycle_start: busy=%b valid=%b after DONE, want 0 0", busy_after, rk_valid_a);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
      int bad = 0;
      model_expand(key);
      capture(key, 0, -1, '0, 0);
      for (int i = 0; i < cap_data.size(); i++)
        if (i > 10 || cap_idx[i] !== i || cap_data[i] !== exp_rk[i]) bad++;
      checks++;
      if (bad != 0 || cap_data.size() != 11 || first_valid != 1 || done_cyc != 12) begin
        errors++; $display("FAIL back_to_back%0d: bad=%0d keys=%0d first=%0d done_at=%0d, want 0 11 1 12",
                           n, bad, cap_data.size(), first_valid, done_cyc);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit hit = 0;
    int dones = 0;
    int bad = 0;
    key_in_a = K1; start_a = 1'b1; rk_ready_a = 1'b1;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (done_a === 1'b1) dones++;
      if (rk_valid_a && rk_index_a == 4'd7) begin rst = 1'b1; hit = 1; end
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (!hit || busy_a !== 1'b0 || rk_valid_a !== 1'b0 || rk_data_a !== '0 || done_a !== 1'b0) begin
      errors++; $display("FAIL mid_reset: reached=%0d busy=%b valid=%b done=%b data=%h, want 1 0 0 0 0",
                         hit, busy_a, rk_valid_a, done_a, rk_data_a);
    end
    repeat (14) begin
      @(negedge clk);
      if (done_a === 1'b1 || rk_valid_a === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL mid_reset_quiet: done/valid cycles=%0d, want 0", dones);
    end
    model_expand(K1);
    capture(K1, 0, -1, '0, 0);
    for (int i = 0; i < cap_data.size(); i++)
      if (i > 10 || cap_idx[i] !== i || cap_data[i] !== exp_rk[i]) bad++;
    checks++;
    if (bad != 0 || cap_data.size() != 11 || done_cnt != 1) begin
      errors++; $display("FAIL post_reset_run: bad=%0d keys=%0d pulses=%0d, want 0 11 1",
                         bad, cap_data.size(), done_cnt);
    end
  endtask

  task automatic test_no_round0();
    int fv = -1, dc = -1, bad = 0, cnt = 0;
    model_expand(K1);
    key_in_b = K1; start_b = 1'b1; rk_ready_b = 1'b1;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if (rk_valid_b === 1'b1) begin
        if (fv < 0) begin
          fv = c;
          checks++;
          if (rk_index_b !== 4'd1 || rk_data_b !== R1) begin
            errors++; $display("FAIL no_r0_first: idx=%0d data=%h, want 1 %h", rk_index_b, rk_data_b, R1);
          end
        end
        cnt++;
        if (cnt > 10 || int'(rk_index_b) != cnt || rk_data_b !== exp_rk[cnt]) bad++;
      end
      if (done_b === 1'b1) dc = c;
    end
    checks++;
    if (fv != 1 || cnt != 10 || bad != 0 || dc != 11) begin
      errors++; $display("FAIL no_r0_seq: first=%0d keys=%0d bad=%0d done_at=%0d, want 1 10 0 11",
                         fv, cnt, bad, dc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_vectors();
    test_backpressure();
    test_zero_key();
    test_start_ignored();
    test_back_to_back();
    test_reset_midstream();
    test_no_round0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
